// File: rtl/data_cache_ctrl.sv
// rtl/data_cache_ctrl.sv - direct-mapped write-back write-allocate data cache controller (optional stats: DATA_CACHE_STATS_EN)
module data_cache_ctrl #(
    parameter int NUM_LINES      = 8,
    parameter int WORDS_PER_LINE = 4,
    parameter int ADDR_W         = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [ADDR_W-1:0] Address,
    input  logic [31:0]       Write_Data,
    input  logic              MemRead,
    input  logic              MemWrite,
    output logic [31:0]       Read_data,
    output logic              Stall,
    output logic [ADDR_W-1:0] Mem_Address,
    output logic [31:0]       Mem_Write_Data,
    output logic              Mem_MemWrite,
    output logic              Mem_MemRead,
    input  logic [31:0]       Mem_Read_data
`ifdef DATA_CACHE_STATS_EN
    ,
    output logic [15:0]       Hit_count,
    output logic [15:0]       Miss_count
`endif
);

    localparam int IDX_W = $clog2(NUM_LINES);
    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int TAG_W = ADDR_W - IDX_W - OFF_W - 2;
    localparam logic [OFF_W-1:0] CNT_LAST = OFF_W'(WORDS_PER_LINE - 1);
    localparam logic [OFF_W-1:0] CNT_ONE  = OFF_W'(1);

    typedef enum logic [1:0] {COMPARE, WRITEBACK, ALLOCATE} state_t;

    state_t             state, next_state;
    logic [OFF_W-1:0]   cnt, next_cnt;
    logic [NUM_LINES-1:0] valid, dirty;
    logic [TAG_W-1:0]   tag_mem  [NUM_LINES];
    logic [31:0]        data_mem [NUM_LINES*WORDS_PER_LINE];

    logic [OFF_W-1:0]   req_off;
    logic [IDX_W-1:0]   req_idx;
    logic [TAG_W-1:0]   req_tag;
    logic               req, hit;
    logic               store_hit, miss, fill_we, fill_last, wb_last;
    logic               unused_byte;

    assign req_off     = Address[OFF_W+1:2];
    assign req_idx     = Address[OFF_W+IDX_W+1:OFF_W+2];
    assign req_tag     = Address[ADDR_W-1:OFF_W+IDX_W+2];
    assign req         = MemRead | MemWrite;
    assign hit         = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign unused_byte = &{1'b0, Address[1:0]};

    // State and burst counter; valid/dirty bookkeeping for the indexed line
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state <= COMPARE;
            cnt   <= '0;
            valid <= '0;
            dirty <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
            if (store_hit) dirty[req_idx] <= 1'b1;
            if (wb_last)   dirty[req_idx] <= 1'b0;
            if (fill_last) begin
                valid[req_idx] <= 1'b1;
                dirty[req_idx] <= 1'b0;
            end
        end
    end

    // Data and tag arrays keep their contents across reset; writes are blocked while reset is held
    always_ff @(posedge CLK) begin
        if (RESET) begin
            if (store_hit) data_mem[{req_idx, req_off}] <= Write_Data;
            if (fill_we)   data_mem[{req_idx, cnt}]     <= Mem_Read_data;
            if (fill_last) tag_mem[req_idx]             <= req_tag;
        end
    end

    // Next-state, CPU-side results and memory burst sequencing
    always_comb begin
        next_state     = state;
        next_cnt       = cnt;
        Read_data      = '0;
        Stall          = 1'b0;
        Mem_Address    = '0;
        Mem_Write_Data = '0;
        Mem_MemWrite   = 1'b0;
        Mem_MemRead    = 1'b0;
        store_hit      = 1'b0;
        miss           = 1'b0;
        fill_we        = 1'b0;
        fill_last      = 1'b0;
        wb_last        = 1'b0;
        case (state)
            COMPARE: begin
                if (req) begin
                    if (hit) begin
                        if (MemWrite) store_hit = 1'b1;
                        else          Read_data = data_mem[{req_idx, req_off}];
                    end else begin
                        miss       = 1'b1;
                        Stall      = 1'b1;
                        next_cnt   = '0;
                        next_state = (valid[req_idx] && dirty[req_idx]) ? WRITEBACK : ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                Stall          = 1'b1;
                Mem_MemWrite   = 1'b1;
                Mem_Address    = {tag_mem[req_idx], req_idx, cnt, 2'b00};
                Mem_Write_Data = data_mem[{req_idx, cnt}];
                if (cnt == CNT_LAST) begin
                    wb_last    = 1'b1;
                    next_state = ALLOCATE;
                    next_cnt   = '0;
                end else begin
                    next_cnt   = cnt + CNT_ONE;
                end
            end
            ALLOCATE: begin
                Stall       = 1'b1;
                Mem_MemRead = 1'b1;
                Mem_Address = {req_tag, req_idx, cnt, 2'b00};
                fill_we     = 1'b1;
                if (cnt == CNT_LAST) begin
                    fill_last  = 1'b1;
                    next_state = COMPARE;
                    next_cnt   = '0;
                end else begin
                    next_cnt   = cnt + CNT_ONE;
                end
            end
            default: begin
                next_state = COMPARE;
                next_cnt   = '0;
            end
        endcase
    end

`ifdef DATA_CACHE_STATS_EN
    logic refill_pending;

    // Saturating hit/miss counters; the hit that completes a refilled request is not a new hit
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            Hit_count      <= '0;
            Miss_count     <= '0;
            refill_pending <= 1'b0;
        end else if (state == COMPARE && req) begin
            if (miss) begin
                refill_pending <= 1'b1;
                if (Miss_count != 16'hFFFF) Miss_count <= Miss_count + 16'd1;
            end else if (refill_pending) begin
                refill_pending <= 1'b0;
            end else if (Hit_count != 16'hFFFF) begin
                Hit_count <= Hit_count + 16'd1;
            end
        end
    end
`endif

endmodule
